// File: rtl/max_unpool_stream.sv
// Streaming 2x2 max-unpool: buffers one pooled row, then emits the two full-resolution rows it covers.
// Define UNPOOL_REPLICATE_EN for nearest-neighbour upsampling (argmax index ignored, not stored).
module max_unpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int OutputH    = 28,
  parameter int OutputW    = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_last,
  output logic                  frame_done
);

  localparam int PoolW = OutputW / 2;
  localparam int PoolH = OutputH / 2;
  localparam int FcolW = (PoolW > 1) ? $clog2(PoolW) : 1;
  localparam int ColW  = FcolW + 1;
  localparam int RowW  = (PoolH > 1) ? $clog2(PoolH) : 1;
`ifdef UNPOOL_REPLICATE_EN
  localparam int EntryW = DATA_WIDTH;
`else
  localparam int EntryW = DATA_WIDTH + 2;
`endif

  typedef enum logic {FILL, EMIT} state_e;

  state_e                stateReg, stateNext;
  logic                  armedReg;
  logic [FcolW-1:0]      fcolReg;
  logic [ColW-1:0]       ocolReg;
  logic                  oparReg;
  logic [RowW-1:0]       prowReg;
  logic [DATA_WIDTH-1:0] outDataReg;
  logic                  frameDoneReg;
  logic [EntryW-1:0]     rowBuf [PoolW];

  logic                  inFire, outFire, fcolEnd, ocolEnd, prowLast, loadPix;
  logic [EntryW-1:0]     wrEntry, rdEntry;
  logic [ColW-1:0]       pfCol;
  logic                  pfPar;
  logic [DATA_WIDTH-1:0] pfPix;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= FILL;
    else        stateReg <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      FILL:    if (inFire && fcolEnd) stateNext = EMIT;
      EMIT:    if (outFire && ocolEnd && oparReg) stateNext = FILL;
      default: stateNext = FILL;
    endcase
  end

  // FSM outputs; armedReg keeps in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = (stateReg == FILL) && armedReg;
    out_valid = (stateReg == EMIT);
  end

  assign inFire   = in_valid && in_ready;
  assign outFire  = out_valid && out_ready;
  assign fcolEnd  = (fcolReg == FcolW'(PoolW - 1));
  assign ocolEnd  = (ocolReg == ColW'(OutputW - 1));
  assign prowLast = (prowReg == RowW'(PoolH - 1));

`ifdef UNPOOL_REPLICATE_EN
  logic unusedRep;
  assign wrEntry   = in_data;
  assign unusedRep = ^{in_idx, pfPar, pfCol[0]};
`else
  assign wrEntry = {in_idx, in_data};
`endif

  // Position of the pixel to prefetch into outDataReg: first pixel of the row pair when
  // filling completes, otherwise the pixel following the one being transferred.
  always_comb begin
    pfCol   = ocolReg + 1'b1;
    pfPar   = oparReg;
    if (ocolEnd) begin
      pfCol = '0;
      pfPar = 1'b1;
    end
    rdEntry = rowBuf[pfCol[ColW-1:1]];
    if (stateReg == FILL) begin
      pfCol   = '0;
      pfPar   = 1'b0;
      rdEntry = (PoolW == 1) ? wrEntry : rowBuf[0];
    end
  end

  always_comb begin
`ifdef UNPOOL_REPLICATE_EN
    pfPix = rdEntry;
`else
    pfPix = (rdEntry[EntryW-1 -: 2] == {pfPar, pfCol[0]}) ? rdEntry[DATA_WIDTH-1:0] : '0;
`endif
  end

  assign loadPix = (inFire && fcolEnd) || (outFire && !(ocolEnd && oparReg));

  // Row buffer has no reset: its contents are only read after a full row is written
  always_ff @(posedge clk) begin
    if (inFire) rowBuf[fcolReg] <= wrEntry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armedReg     <= 1'b0;
      fcolReg      <= '0;
      ocolReg      <= '0;
      oparReg      <= 1'b0;
      prowReg      <= '0;
      outDataReg   <= '0;
      frameDoneReg <= 1'b0;
    end else begin
      armedReg     <= 1'b1;
      frameDoneReg <= outFire && out_last;
      if (inFire) fcolReg <= fcolEnd ? '0 : fcolReg + 1'b1;
      if (loadPix) outDataReg <= pfPix;
      if (outFire) begin
        if (ocolEnd) begin
          ocolReg <= '0;
          oparReg <= ~oparReg;
          if (oparReg) prowReg <= prowLast ? '0 : prowReg + 1'b1;
        end else begin
          ocolReg <= ocolReg + 1'b1;
        end
      end
    end
  end

  assign out_data   = outDataReg;
  assign out_sof    = out_valid && (prowReg == '0) && !oparReg && (ocolReg == '0);
  assign out_last   = out_valid && prowLast && oparReg && ocolEnd;
  assign frame_done = frameDoneReg;

endmodule

// File: tb/tb_max_unpool_stream.sv
// Directed testbench for max_unpool_stream (28x28 map, 16-bit pixels).
module tb_max_unpool_stream;

  localparam int DW   = 16;
  localparam int OH   = 28;
  localparam int OW   = 28;
  localparam int PW   = OW / 2;
  localparam int PH   = OH / 2;
  localparam int NPIX = OH * OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_idx = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sof, out_last, frame_done;

  max_unpool_stream #(.DATA_WIDTH(DW), .OutputH(OH), .OutputW(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_last(out_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  int cyc = 0, accCnt = 0, xfrCnt = 0, fdCnt = 0, fdCyc = -1, lastCyc = -1, overlapCnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) accCnt <= accCnt + 1;
    if (out_valid && out_ready) begin
      xfrCnt <= xfrCnt + 1;
      if (out_last) lastCyc <= cyc;
    end
    if (frame_done) begin
      fdCnt <= fdCnt + 1;
      fdCyc <= cyc;
    end
    if (in_ready && out_valid) overlapCnt <= overlapCnt + 1;
  end

  logic [DW-1:0] rxData [2*NPIX];
  bit            rxSof  [2*NPIX];
  bit            rxLast [2*NPIX];
  int            rxN;
  bit            timedOut;
  bit            holdValid = 1'b0;

  // Pooled frame contents: row 0 is the directed pattern, other rows vary value and index.
  function automatic logic [DW-1:0] pooledVal(input int r, input int c);
    if (r == 0) return (c == 0) ? 16'h4500 : (c == 1) ? 16'h4400 : 16'h4000;
    return DW'(16'h1000 + r * 32 + c);
  endfunction

  function automatic logic [1:0] pooledIdx(input int r, input int c);
    if (r == 0) return (c == 0) ? 2'd3 : (c == 1) ? 2'd0 : 2'd1;
    return 2'((r + c) % 4);
  endfunction

  function automatic logic [DW-1:0] expPix(input int y, input int x);
    logic [1:0] pos;
    pos = 2'((y % 2) * 2 + (x % 2));
`ifdef UNPOOL_REPLICATE_EN
    if (pos == 2'b00 || pos != 2'b00) return pooledVal(y / 2, x / 2);
    return '0;
`else
    return (pooledIdx(y / 2, x / 2) == pos) ? pooledVal(y / 2, x / 2) : '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input int r, input int c0, input int c1, input bit rnd);
    for (int c = c0; c < c1; c++) begin
      int n = 0;
      if (rnd) begin
        int g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) step();
      end
      in_valid = 1'b1;
      in_data  = pooledVal(r, c);
      in_idx   = pooledIdx(r, c);
      while (!in_ready && n < 100) begin
        step();
        n++;
      end
      if (n >= 100) timedOut = 1'b1;
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic recv_pixels(input int count, input bit bp);
    in_valid = holdValid;
    in_data  = 16'hDEAD;
    in_idx   = 2'b11;
    for (int k = 0; k < count; k++) begin
      int n = 0;
      bit got = 1'b0;
      while (!got && n < 100) begin
        out_ready = bp ? ~out_ready : 1'b1;
        if (out_valid && out_ready && rxN < 2 * NPIX) begin
          rxData[rxN] = out_data;
          rxSof[rxN]  = out_sof;
          rxLast[rxN] = out_last;
          rxN++;
          got = 1'b1;
        end
        step();
        n++;
      end
      if (!got) timedOut = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_frame(input bit bp, input bit rnd);
    for (int r = 0; r < PH; r++) begin
      send_row(r, 0, PW, rnd);
      recv_pixels(2 * OW, bp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if ({in_ready, out_valid, out_sof, out_last, frame_done} !== 5'b0) begin
        fails++;
        $display("FAIL reset_outputs got %b want 00000", {in_ready, out_valid, out_sof, out_last, frame_done});
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge got %b want 0", in_ready); end
    step();
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge got %b want 1", in_ready); end
    timedOut = 1'b0;
    send_row(0, 0, PW - 1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL valid_after_13 got %b want 0", out_valid); end
    send_row(0, PW - 1, PW, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL latency_after_14 valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready);
    end
    checks++;
    if (out_data !== expPix(0, 0) || out_sof !== 1'b1) begin
      fails++;
      $display("FAIL first_pixel data=%h sof=%b want data=%h sof=1", out_data, out_sof, expPix(0, 0));
    end
    checks++;
    if (timedOut) begin fails++; $display("FAIL reset_timeout got 1 want 0"); end
    $display("test_reset: done");
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_argmax();
    int acc0 = accCnt, xfr0 = xfrCnt;
    logic [DW-1:0] row0Exp [8];
    logic [DW-1:0] row1Exp [8];
`ifdef UNPOOL_REPLICATE_EN
    row0Exp = '{16'h4500, 16'h4500, 16'h4400, 16'h4400, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
    row1Exp = '{16'h4500, 16'h4500, 16'h4400, 16'h4400, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
`else
    row0Exp = '{16'h0000, 16'h0000, 16'h4400, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h4000};
    row1Exp = '{16'h0000, 16'h4500, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
    rxN = 0;
    timedOut = 1'b0;
    do_frame(1'b0, 1'b0);
    repeat (3) step();
    checks++;
    if (timedOut || rxN !== NPIX) begin fails++; $display("FAIL argmax_count rx=%0d timeout=%b want %0d", rxN, timedOut, NPIX); end
    checks++;
    if (accCnt - acc0 !== NPIX / 4 || xfrCnt - xfr0 !== NPIX) begin
      fails++;
      $display("FAIL argmax_handshakes acc=%0d xfr=%0d want 196/784", accCnt - acc0, xfrCnt - xfr0);
    end
    for (int x = 0; x < 8; x++) begin
      checks++;
      if (rxData[x] !== row0Exp[x]) begin fails++; $display("FAIL argmax_row0[%0d] got %h want %h", x, rxData[x], row0Exp[x]); end
      checks++;
      if (rxData[OW + x] !== row1Exp[x]) begin fails++; $display("FAIL argmax_row1[%0d] got %h want %h", x, rxData[OW + x], row1Exp[x]); end
    end
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if (rxData[k] !== expPix(k / OW, k % OW)) begin
        fails++;
        $display("FAIL argmax_pix[%0d] got %h want %h", k, rxData[k], expPix(k / OW, k % OW));
      end
    end
    $display("test_argmax: %0d pixels received", rxN);
  endtask

  task automatic test_backpressure();
    int acc0 = accCnt, xfr0 = xfrCnt;
    rxN = 0;
    timedOut = 1'b0;
    do_frame(1'b1, 1'b1);
    repeat (3) step();
    checks++;
    if (timedOut || rxN !== NPIX) begin fails++; $display("FAIL bp_count rx=%0d timeout=%b want %0d", rxN, timedOut, NPIX); end
    checks++;
    if (accCnt - acc0 !== NPIX / 4 || xfrCnt - xfr0 !== NPIX) begin
      fails++;
      $display("FAIL bp_handshakes acc=%0d xfr=%0d want 196/784", accCnt - acc0, xfrCnt - xfr0);
    end
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if (rxData[k] !== expPix(k / OW, k % OW) || rxSof[k] !== (k == 0) || rxLast[k] !== (k == NPIX - 1)) begin
        fails++;
        $display("FAIL bp_pix[%0d] got %h sof=%b last=%b want %h", k, rxData[k], rxSof[k], rxLast[k], expPix(k / OW, k % OW));
      end
    end
    $display("test_backpressure: %0d pixels received", rxN);
  endtask

  task automatic test_frame_boundary();
    int acc0 = accCnt, fd0 = fdCnt, ov0 = overlapCnt;
    rxN = 0;
    timedOut = 1'b0;
    holdValid = 1'b1;
    do_frame(1'b0, 1'b0);
    do_frame(1'b0, 1'b0);
    holdValid = 1'b0;
    repeat (3) step();
    checks++;
    if (timedOut || rxN !== 2 * NPIX) begin fails++; $display("FAIL fb_count rx=%0d timeout=%b want %0d", rxN, timedOut, 2 * NPIX); end
    checks++;
    if (accCnt - acc0 !== NPIX / 2) begin fails++; $display("FAIL fb_accepted got %0d want 392", accCnt - acc0); end
    checks++;
    if (overlapCnt - ov0 !== 0) begin fails++; $display("FAIL fb_ready_in_emit got %0d want 0", overlapCnt - ov0); end
    checks++;
    if (fdCnt - fd0 !== 2) begin fails++; $display("FAIL fb_done_cycles got %0d want 2", fdCnt - fd0); end
    checks++;
    if (fdCyc !== lastCyc + 1) begin fails++; $display("FAIL fb_done_timing got %0d want %0d", fdCyc, lastCyc + 1); end
    for (int k = 0; k < 2 * NPIX; k++) begin
      checks++;
      if (rxSof[k] !== (k == 0 || k == NPIX) || rxLast[k] !== (k == NPIX - 1 || k == 2 * NPIX - 1)) begin
        fails++;
        $display("FAIL fb_flags[%0d] sof=%b last=%b want sof=%b last=%b", k, rxSof[k], rxLast[k],
                 (k == 0 || k == NPIX), (k == NPIX - 1 || k == 2 * NPIX - 1));
      end
      checks++;
      if (rxData[k] !== expPix((k % NPIX) / OW, k % OW)) begin
        fails++;
        $display("FAIL fb_pix[%0d] got %h want %h", k, rxData[k], expPix((k % NPIX) / OW, k % OW));
      end
    end
    $display("test_frame_boundary: %0d pixels, %0d frame_done cycles", rxN, fdCnt - fd0);
  endtask

  task automatic test_mid_emit_reset();
    rxN = 0;
    timedOut = 1'b0;
    send_row(0, 0, PW, 1'b0);
    recv_pixels(20, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_async valid=%b ready=%b want 0/0", out_valid, in_ready);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready got %b want 1", in_ready); end
    send_row(0, 0, PW, 1'b0);
    recv_pixels(1, 1'b0);
    checks++;
    if (timedOut || rxN !== 21) begin fails++; $display("FAIL mid_reset_count rx=%0d timeout=%b want 21", rxN, timedOut); end
    checks++;
    if (rxSof[20] !== 1'b1 || rxData[20] !== expPix(0, 0)) begin
      fails++;
      $display("FAIL mid_reset_restart sof=%b data=%h want sof=1 data=%h", rxSof[20], rxData[20], expPix(0, 0));
    end
    checks++;
    if (rxData[2] !== expPix(0, 2)) begin fails++; $display("FAIL mid_reset_pix2 got %h want %h", rxData[2], expPix(0, 2)); end
    $display("test_mid_emit_reset: restart sof=%b", rxSof[20]);
  endtask

  initial begin
    test_reset();
    test_argmax();
    test_backpressure();
    test_frame_boundary();
    test_mid_emit_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
